// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with a memory-handshake timeout trap.
// Define UPPER_IMM_EN to add LUI/AUIPC support through the UPPER state.
module multicycle_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [3:0] State,
  output logic       Trap
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
`ifdef UPPER_IMM_EN
    UPPER    = 4'd11,
`endif
    JALR     = 4'd12,
    TRAP     = 4'd15
  } state_t;

  state_t     state_r;
  state_t     next_s;
  logic [7:0] wait_cnt_r;
  logic       timeout_s;
  logic       mem_req_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic       adr_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_op_s;
  logic       unused_s;

  // funct7b5 belongs to the ALU decoder, not to this sequencer
  assign unused_s  = funct7b5;
  assign timeout_s = (wait_cnt_r == TIMEOUT) && !MemReady;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Wait counter: restarts on every state change, counts unanswered requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_r <= 8'd0;
    end else if (next_s != state_r) begin
      wait_cnt_r <= 8'd0;
    end else if (mem_req_s && !MemReady) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Immediate format select, decoded from the opcode in every state
  always_comb begin
    ImmSrc = 3'b000;
    case (Op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
`ifdef UPPER_IMM_EN
      OP_LUI,
      OP_AUIPC:  ImmSrc = 3'b100;
`endif
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Next-state and Moore control decode
  always_comb begin
    next_s       = state_r;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    alu_op_s     = 2'b00;
    case (state_r)
      FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        if (MemReady) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          next_s     = DECODE;
        end else if (timeout_s) begin
          next_s = TRAP;
        end else begin
          next_s = FETCH;
        end
      end
      DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (Op)
          OP_LOAD,
          OP_STORE:  next_s = MEMADR;
          OP_RTYPE:  next_s = EXECR;
          OP_ITYPE:  next_s = EXECI;
          OP_JAL:    next_s = JAL;
          // jalr first computes RegA+imm into ALUOut via EXECI, then links in JALR
          OP_JALR:   next_s = EXECI;
          OP_BRANCH: next_s = BRANCH;
`ifdef UPPER_IMM_EN
          OP_LUI,
          OP_AUIPC:  next_s = UPPER;
`endif
          default:   next_s = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (Op == OP_STORE) begin
          next_s = MEMWRITE;
        end else if (Op == OP_LOAD) begin
          next_s = MEMREAD;
        end else begin
          next_s = TRAP;
        end
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (MemReady) begin
          next_s = MEMWB;
        end else if (timeout_s) begin
          next_s = TRAP;
        end else begin
          next_s = MEMREAD;
        end
      end
      MEMWB: begin
        reg_write_s  = 1'b1;
        result_src_s = 2'b01;
        next_s       = FETCH;
      end
      MEMWRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        if (MemReady) begin
          next_s = FETCH;
        end else if (timeout_s) begin
          next_s = TRAP;
        end else begin
          next_s = MEMWRITE;
        end
      end
      EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        next_s      = ALUWB;
      end
      EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        next_s      = (Op == OP_JALR) ? JALR : ALUWB;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        next_s      = FETCH;
      end
      JAL, JALR: begin
        pc_write_s  = 1'b1;
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        next_s      = ALUWB;
      end
      BRANCH: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        pc_write_s  = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
        if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
          next_s = FETCH;
        end else begin
          next_s = TRAP;
        end
      end
`ifdef UPPER_IMM_EN
      UPPER: begin
        alu_src_a_s = (Op == OP_AUIPC) ? 2'b01 : 2'b10;
        alu_src_b_s = 2'b01;
        next_s      = ALUWB;
      end
`endif
      TRAP: begin
        next_s = TRAP;
      end
      default: begin
        next_s = TRAP;
      end
    endcase
  end

  // Strobes are forced low in a reset cycle so an abandoned operation pulses nothing
  assign MemReq    = mem_req_s   & rst_n;
  assign MemWrite  = mem_write_s & rst_n;
  assign IRWrite   = ir_write_s  & rst_n;
  assign PCWrite   = pc_write_s  & rst_n;
  assign RegWrite  = reg_write_s & rst_n;
  assign AdrSrc    = adr_src_s;
  assign ALUSrcA   = alu_src_a_s;
  assign ALUSrcB   = alu_src_b_s;
  assign ResultSrc = result_src_s;
  assign ALUOp     = alu_op_s;
  assign State     = state_r;
  assign Trap      = (state_r == TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams checked against a per-instruction state-sequence model.
module tb_multicycle_ctrl;

  localparam logic [7:0] TO = 8'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMREAD = 4'd3, S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR = 4'd6,  S_ALUWB = 4'd7,   S_EXECI = 4'd8;
  localparam logic [3:0] S_JAL = 4'd9,    S_BRANCH = 4'd10, S_UPPER = 4'd11;
  localparam logic [3:0] S_JALR = 4'd12,  S_TRAP = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, Trap;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] State;
  logic [17:0] ctrl_got;

  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_z  = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .State(State), .Trap(Trap)
  );

  always #5 clk = ~clk;

  assign ctrl_got = {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
                     ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, Trap};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rnd_bit();
    return (($urandom() & 32'd1) != 32'd0);
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      OP_STORE:  return 3'b001;
      OP_BRANCH: return 3'b010;
      OP_JAL:    return 3'b011;
`ifdef UPPER_IMM_EN
      OP_LUI, OP_AUIPC: return 3'b100;
`endif
      default:   return 3'b000;
    endcase
  endfunction

  // Expected control word for a state, straight from the per-state output table
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic [6:0] op, input logic [2:0] f3,
                                           input logic z);
    logic mreq = 1'b0, mw = 1'b0, irw = 1'b0, pcw = 1'b0, rw = 1'b0, adr = 1'b0, trp = 1'b0;
    logic [1:0] sa = 2'b00, sb = 2'b00, res = 2'b00, aop = 2'b00;
    case (st)
      S_FETCH:    begin mreq = 1'b1; sb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  begin mreq = 1'b1; adr = 1'b1; end
      S_MEMWB:    begin rw = 1'b1; res = 2'b01; end
      S_MEMWRITE: begin mreq = 1'b1; mw = 1'b1; adr = 1'b1; end
      S_EXECR:    begin sa = 2'b10; aop = 2'b10; end
      S_ALUWB:    begin rw = 1'b1; end
      S_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      S_JAL, S_JALR: begin pcw = 1'b1; sa = 2'b01; sb = 2'b10; end
      S_BRANCH:   begin
        sa = 2'b10; aop = 2'b01;
        pcw = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
      end
      S_UPPER:    begin sb = 2'b01; sa = (op == OP_AUIPC) ? 2'b01 : 2'b10; end
      S_TRAP:     trp = 1'b1;
      default:    trp = 1'b1;
    endcase
    return {mreq, mw, irw, pcw, rw, adr, sa, sb, res, aop, exp_imm(op), trp};
  endfunction

  task automatic step(input logic [3:0] st, input logic rdy);
    @(negedge clk);
    Op = cur_op; funct3 = cur_f3; Zero = cur_z; funct7b5 = rnd_bit(); MemReady = rdy;
    #1;
    check($sformatf("state(exp %0d)", st), {28'd0, State}, {28'd0, st});
    check($sformatf("ctrl@%0d", st), {14'd0, ctrl_got},
          {14'd0, exp_ctrl(st, rdy, cur_op, cur_f3, cur_z)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; MemReady = rnd_bit();
    #1;
    check("rst strobes", {27'd0, MemReq, MemWrite, IRWrite, PCWrite, RegWrite}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Memory handshake: up to TO unanswered cycles are tolerated, one more traps
  task automatic mem_phase(input logic [3:0] st, input int w, output logic tr);
    int lim = int'(TO);
    int n = (w > lim) ? lim + 1 : w;
    for (int i = 0; i < n; i++) step(st, 1'b0);
    if (w > lim) begin
      tr = 1'b1;
    end else begin
      step(st, 1'b1);
      tr = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int wf, input int wm);
    logic tr;
    cur_op = op; cur_f3 = f3; cur_z = z;
    mem_phase(S_FETCH, wf, tr);
    if (!tr) begin
      step(S_DECODE, rnd_bit());
      case (op)
        OP_LOAD: begin
          step(S_MEMADR, rnd_bit());
          mem_phase(S_MEMREAD, wm, tr);
          if (!tr) step(S_MEMWB, rnd_bit());
        end
        OP_STORE: begin
          step(S_MEMADR, rnd_bit());
          mem_phase(S_MEMWRITE, wm, tr);
        end
        OP_RTYPE:  begin step(S_EXECR, rnd_bit()); step(S_ALUWB, rnd_bit()); end
        OP_ITYPE:  begin step(S_EXECI, rnd_bit()); step(S_ALUWB, rnd_bit()); end
        OP_JAL:    begin step(S_JAL, rnd_bit());   step(S_ALUWB, rnd_bit()); end
        OP_JALR: begin
          step(S_EXECI, rnd_bit()); step(S_JALR, rnd_bit()); step(S_ALUWB, rnd_bit());
        end
        OP_BRANCH: begin
          step(S_BRANCH, rnd_bit());
          tr = !((f3 == 3'b000) || (f3 == 3'b001));
        end
        OP_LUI, OP_AUIPC: begin
`ifdef UPPER_IMM_EN
          step(S_UPPER, rnd_bit()); step(S_ALUWB, rnd_bit());
`else
          tr = 1'b1;
`endif
        end
        default: tr = 1'b1;
      endcase
    end
    if (tr) begin
      for (int i = 0; i < 4; i++) step(S_TRAP, rnd_bit());
      do_reset();
    end
  endtask

  logic [6:0] op_pool [11] = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR,
                               OP_BRANCH, OP_LUI, OP_AUIPC, 7'b1111111, 7'b0001111};

  initial begin
    logic tr;
    do_reset();
    // add with MemReady always high: 0,1,6,7
    run_instr(OP_RTYPE, 3'b000, 1'b0, 0, 0);
    // lw with 3-cycle waits in FETCH and MEMREAD
    run_instr(OP_LOAD, 3'b010, 1'b0, 3, 3);
    // beq then bne, both with Zero=1
    run_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 3'b001, 1'b1, 0, 0);
    // handshake exactly at the limit wins; one more cycle traps
    run_instr(OP_ITYPE, 3'b000, 1'b0, int'(TO), 0);
    run_instr(OP_RTYPE, 3'b000, 1'b0, int'(TO) + 1, 0);
    run_instr(OP_STORE, 3'b010, 1'b0, 0, int'(TO) + 1);
    // upper-immediate opcode, illegal opcode, illegal branch funct3
    run_instr(OP_LUI, 3'b000, 1'b0, 0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 3'b100, 1'b0, 0, 0);
    // reset while MEMWRITE is waiting, then a full-length wait must not trap
    cur_op = OP_STORE; cur_f3 = 3'b010; cur_z = 1'b0;
    mem_phase(S_FETCH, 0, tr);
    step(S_DECODE, rnd_bit());
    step(S_MEMADR, rnd_bit());
    for (int i = 0; i < 3; i++) step(S_MEMWRITE, 1'b0);
    do_reset();
    run_instr(OP_RTYPE, 3'b000, 1'b0, int'(TO), 0);

    for (int k = 0; k < 200; k++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int wf, wm, r;
      op = op_pool[$urandom_range(0, 10)];
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 31));
      wf = (r == 0) ? int'(TO) + 1 : (r == 1) ? int'(TO) : int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 31));
      wm = (r == 0) ? int'(TO) + 1 : (r == 1) ? int'(TO) : int'($urandom_range(0, 3));
      run_instr(op, f3, rnd_bit(), wf, wm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
